// File: rtl/cfg_stream_pkg.sv
// Shared state encoding and elaboration-time helpers for the config word streamer.
package cfg_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_SETTLE = 3'd5,
    S_URST   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_byte_packer.sv
// Inserts incoming bytes into word lanes and flags a completed (full or last) word.
// The accumulator clears on completion, so a short final word is zero-padded.
module cfg_byte_packer
  import cfg_stream_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              is_last
);

  localparam int NB    = WORD_W / 32'sd8;
  localparam int IDX_W = (NB > 32'sd1) ? clog2(NB) : 32'sd1;
  localparam logic [IDX_W-1:0] NB_M1 = IDX_W'(NB - 32'sd1);

  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  lane_s;
  logic [WORD_W-1:0] acc_r;
  logic [WORD_W-1:0] word_s;

  // Accumulated word with the current byte dropped into its lane
  always_comb begin
    if (MSB_FIRST) begin
      lane_s = NB_M1 - idx_r;
    end else begin
      lane_s = idx_r;
    end
    word_s = acc_r;
    word_s[{lane_s, 3'b000} +: 8] = byte_data;
  end

  assign word       = word_s;
  assign word_valid = take && (byte_last || (idx_r == NB_M1));
  assign is_last    = take && byte_last;

  // Lane accumulator and byte index
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idx_r <= '0;
      acc_r <= '0;
    end else if (clear || word_valid) begin
      idx_r <= '0;
      acc_r <= '0;
    end else if (take) begin
      idx_r <= idx_r + 1'b1;
      acc_r <= word_s;
    end else begin
      idx_r <= idx_r;
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/cfg_word_streamer.sv
// Streams packed config words onto the fabric self-write port with setup/strobe/hold
// timing, then waits a settle time and pulses the user-design reset.
module cfg_word_streamer
  import cfg_stream_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 2,
  parameter int MAX_WORDS  = 4096,
  parameter int SETTLE_CYC = 100,
  parameter int URST_CYC   = 5
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic                                start,
  input  logic [7:0]                          byte_data,
  input  logic                                byte_valid,
  input  logic                                byte_last,
  output logic                                byte_ready,
  output logic [WORD_W-1:0]                   SelfWriteData,
  output logic                                SelfWriteStrobe,
  output logic                                user_rst,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [clog2(MAX_WORDS + 32'sd1)-1:0] word_count
);

  localparam int WC_W    = clog2(MAX_WORDS + 32'sd1);
  localparam int TMR_MAX = max2(max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, SETTLE_CYC)), URST_CYC);
  localparam int TMR_W   = clog2(TMR_MAX + 32'sd1);
  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 32'sd1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 32'sd1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'((HOLD_CYC > 32'sd0) ? HOLD_CYC - 32'sd1 : 32'sd0);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYC > 32'sd0) ? SETTLE_CYC - 32'sd1 : 32'sd0);
  localparam logic [TMR_W-1:0] URST_LD   = TMR_W'((URST_CYC > 32'sd0) ? URST_CYC - 32'sd1 : 32'sd0);
  localparam logic [WC_W-1:0]  MAX_WC    = WC_W'(MAX_WORDS);

  state_e            state_r, state_nxt;
  state_e            post_hold_state_s, post_settle_state_s;
  logic [TMR_W-1:0]  timer_r, timer_nxt;
  logic [TMR_W-1:0]  post_hold_timer_s, post_settle_timer_s;
  logic [WC_W-1:0]   word_count_r;
  logic [WORD_W-1:0] data_r;
  logic [WORD_W-1:0] word_s;
  logic              last_r, err_r, byte_ready_r, strobe_r, user_rst_r, busy_r, done_r;
  logic              start_acc_s, take_s, word_valid_s, is_last_s;
  logic              tmr_zero_s, overrun_s, enter_strobe_s, set_err_s;

  assign start_acc_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign take_s      = byte_valid && byte_ready_r;
  assign tmr_zero_s  = (timer_r == '0);
  assign overrun_s   = !last_r && (word_count_r == MAX_WC);

  cfg_byte_packer #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .CLK        (CLK),
    .resetn     (resetn),
    .clear      (start_acc_s),
    .take       (take_s),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word       (word_s),
    .word_valid (word_valid_s),
    .is_last    (is_last_s)
  );

  // Next state, shared timer reload and strobe/error events
  always_comb begin
    state_nxt      = state_r;
    timer_nxt      = timer_r;
    enter_strobe_s = 1'b0;
    set_err_s      = 1'b0;

    if (URST_CYC > 32'sd0) begin
      post_settle_state_s = S_URST;
      post_settle_timer_s = URST_LD;
    end else begin
      post_settle_state_s = S_DONE;
      post_settle_timer_s = '0;
    end

    if (last_r) begin
      if (SETTLE_CYC > 32'sd0) begin
        post_hold_state_s = S_SETTLE;
        post_hold_timer_s = SETTLE_LD;
      end else begin
        post_hold_state_s = post_settle_state_s;
        post_hold_timer_s = post_settle_timer_s;
      end
    end else if (overrun_s) begin
      post_hold_state_s = S_DONE;
      post_hold_timer_s = '0;
    end else begin
      post_hold_state_s = S_FILL;
      post_hold_timer_s = '0;
    end

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_FILL;
        else       state_nxt = state_r;
      end
      S_FILL: begin
        if (word_valid_s) begin
          state_nxt = S_SETUP;
          timer_nxt = SETUP_LD;
        end else begin
          state_nxt = S_FILL;
        end
      end
      S_SETUP: begin
        if (tmr_zero_s) begin
          state_nxt      = S_STROBE;
          timer_nxt      = STROBE_LD;
          enter_strobe_s = 1'b1;
        end else begin
          timer_nxt = timer_r - 1'b1;
        end
      end
      S_STROBE: begin
        if (!tmr_zero_s) begin
          timer_nxt = timer_r - 1'b1;
        end else if (HOLD_CYC > 32'sd0) begin
          state_nxt = S_HOLD;
          timer_nxt = HOLD_LD;
        end else begin
          state_nxt = post_hold_state_s;
          timer_nxt = post_hold_timer_s;
          set_err_s = overrun_s;
        end
      end
      S_HOLD: begin
        if (!tmr_zero_s) begin
          timer_nxt = timer_r - 1'b1;
        end else begin
          state_nxt = post_hold_state_s;
          timer_nxt = post_hold_timer_s;
          set_err_s = overrun_s;
        end
      end
      S_SETTLE: begin
        if (!tmr_zero_s) begin
          timer_nxt = timer_r - 1'b1;
        end else begin
          state_nxt = post_settle_state_s;
          timer_nxt = post_settle_timer_s;
        end
      end
      S_URST: begin
        if (!tmr_zero_s) begin
          timer_nxt = timer_r - 1'b1;
        end else begin
          state_nxt = S_DONE;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // State, datapath and outputs registered from the next-state decode
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      timer_r      <= '0;
      word_count_r <= '0;
      data_r       <= '0;
      last_r       <= 1'b0;
      err_r        <= 1'b0;
      byte_ready_r <= 1'b0;
      strobe_r     <= 1'b0;
      user_rst_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      timer_r      <= timer_nxt;
      byte_ready_r <= (state_nxt == S_FILL);
      strobe_r     <= (state_nxt == S_STROBE);
      user_rst_r   <= (state_nxt == S_URST);
      busy_r       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_r       <= (state_nxt == S_DONE);
      if (start_acc_s) begin
        word_count_r <= '0;
        err_r        <= 1'b0;
        last_r       <= 1'b0;
      end else begin
        if (enter_strobe_s) word_count_r <= word_count_r + 1'b1;
        if (set_err_s) err_r <= 1'b1;
        if (word_valid_s) begin
          data_r <= word_s;
          last_r <= is_last_s;
        end
      end
    end
  end

  assign byte_ready      = byte_ready_r;
  assign SelfWriteData   = data_r;
  assign SelfWriteStrobe = strobe_r;
  assign user_rst        = user_rst_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign err             = err_r;
  assign word_count      = word_count_r;

endmodule
